// File: rtl/fc_infer_if.sv
// Handshake bundle between the FC-layer argmax initiator and its environment:
// the FC valid/ready request side and the result_valid/result_ack bus side.
interface fc_infer_if;
  logic       start;
  logic       busy;
  logic       fc_valid;
  logic       fc_ready;
  logic [7:0] num_0, num_1, num_2, num_3, num_4;
  logic [7:0] num_5, num_6, num_7, num_8, num_9;
  logic       result_valid;
  logic       result_ack;
  logic [3:0] class_idx;
  logic [7:0] class_score;
  logic       timeout_err;

  modport master (
    input  start, fc_ready, result_ack,
    input  num_0, num_1, num_2, num_3, num_4, num_5, num_6, num_7, num_8, num_9,
    output busy, fc_valid, result_valid, class_idx, class_score, timeout_err
  );

  modport slave (
    output start, fc_ready, result_ack,
    output num_0, num_1, num_2, num_3, num_4, num_5, num_6, num_7, num_8, num_9,
    input  busy, fc_valid, result_valid, class_idx, class_score, timeout_err
  );
endinterface

// File: rtl/fc_infer_initiator.sv
// Requests FC-layer scores over valid/ready, snapshots them, scans for the argmax
// and presents it over result_valid/result_ack. Optional macro: FC_INFER_TIMEOUT_EN.
module fc_infer_initiator #(
  parameter bit          SIGNED_SCORES  = 1'b1,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
  input  logic       clk,
  input  logic       rst_n,
  fc_infer_if.master bus
);
  localparam int         DATA_W    = 8;
  localparam int         CLASSES   = 10;
  localparam logic [3:0] LAST_IDX  = 4'd9;
  localparam logic [3:0] ABORT_IDX = 4'hF;

  typedef enum logic [2:0] {IDLE, REQ, SCAN, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              fc_valid_r;
  logic              result_valid_r;
  logic [3:0]        class_idx_r;
  logic [DATA_W-1:0] class_score_r;
  logic [DATA_W-1:0] num_in [CLASSES];
  logic [DATA_W-1:0] snap_p0 [CLASSES];
  logic [DATA_W-1:0] best_score_p1;
  logic [3:0]        best_idx_p1;
  logic              tmo_hit;
  logic              accept, capture, scan_step, scan_last, abort, publish, retire;

  // Strict greater-than in the configured number system; ties keep the incumbent.
  function automatic logic score_gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic signed [DATA_W:0] sa, sb;
    sa = SIGNED_SCORES ? {a[DATA_W-1], a} : {1'b0, a};
    sb = SIGNED_SCORES ? {b[DATA_W-1], b} : {1'b0, b};
    return sa > sb;
  endfunction

  assign num_in[0] = bus.num_0;
  assign num_in[1] = bus.num_1;
  assign num_in[2] = bus.num_2;
  assign num_in[3] = bus.num_3;
  assign num_in[4] = bus.num_4;
  assign num_in[5] = bus.num_5;
  assign num_in[6] = bus.num_6;
  assign num_in[7] = bus.num_7;
  assign num_in[8] = bus.num_8;
  assign num_in[9] = bus.num_9;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    scan_step = 1'b0;
    scan_last = 1'b0;
    abort     = 1'b0;
    publish   = 1'b0;
    retire    = 1'b0;
    unique case (state)
      IDLE: if (bus.start) begin
        accept    = 1'b1;
        state_nxt = REQ;
      end
      REQ: begin
        if (bus.fc_ready) begin
          capture   = 1'b1;
          state_nxt = SCAN;
        end else if (tmo_hit) begin
          abort     = 1'b1;
          state_nxt = DRAIN;
        end
      end
      SCAN: begin
        scan_step = 1'b1;
        if (cnt == LAST_IDX) begin
          scan_last = 1'b1;
          state_nxt = DRAIN;
        end
      end
      // The FC layer must drop ready before we publish, so the next request starts clean.
      DRAIN: if (!bus.fc_ready) begin
        publish   = 1'b1;
        state_nxt = DONE;
      end
      DONE: if (bus.result_ack) begin
        retire    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fc_valid_r     <= 1'b0;
      result_valid_r <= 1'b0;
      class_idx_r    <= '0;
      class_score_r  <= '0;
      cnt            <= '0;
    end else begin
      if (accept)                fc_valid_r <= 1'b1;
      else if (capture || abort) fc_valid_r <= 1'b0;

      if (capture)        cnt <= 4'd1;
      else if (scan_last) cnt <= '0;
      else if (scan_step) cnt <= cnt + 4'd1;

      if (publish)     result_valid_r <= 1'b1;
      else if (retire) result_valid_r <= 1'b0;

      if (abort) begin
        class_idx_r   <= ABORT_IDX;
        class_score_r <= '0;
      end else if (publish) begin
        class_idx_r   <= best_idx_p1;
        class_score_r <= best_score_p1;
      end
    end
  end

  // Stage p0: snapshot of the FC scores; stage p1: running argmax over the snapshot.
  always_ff @(posedge clk) begin
    if (capture) begin
      snap_p0       <= num_in;
      best_score_p1 <= num_in[0];
      best_idx_p1   <= '0;
    end else if (abort) begin
      best_score_p1 <= '0;
      best_idx_p1   <= ABORT_IDX;
    end else if (scan_step && score_gt(snap_p0[cnt], best_score_p1)) begin
      best_score_p1 <= snap_p0[cnt];
      best_idx_p1   <= cnt;
    end
  end

`ifdef FC_INFER_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        timeout_err_r;

  assign tmo_hit = (state == REQ) && (tmo_cnt == TIMEOUT_CYCLES - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt       <= '0;
      timeout_err_r <= 1'b0;
    end else begin
      if (accept)            tmo_cnt <= '0;
      else if (state == REQ) tmo_cnt <= tmo_cnt + 16'd1;

      if (accept)     timeout_err_r <= 1'b0;
      else if (abort) timeout_err_r <= 1'b1;
    end
  end

  assign bus.timeout_err = timeout_err_r;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg  = ^TIMEOUT_CYCLES;
  assign tmo_hit         = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.busy         = (state != IDLE);
  assign bus.fc_valid     = fc_valid_r;
  assign bus.result_valid = result_valid_r;
  assign bus.class_idx    = class_idx_r;
  assign bus.class_score  = class_score_r;
endmodule

// File: tb/tb_fc_infer_initiator.sv
// Scoreboard bench for fc_infer_initiator: a signed and an unsigned instance run
// in lockstep from one FC-layer model; expected argmax results are queued per request.
module tb_fc_infer_initiator;
`ifdef FC_INFER_TIMEOUT_EN
  localparam logic [15:0] TMO = 16'd8;
`else
  localparam logic [15:0] TMO = 16'd4096;
`endif

  typedef struct packed {
    logic [3:0] idx;
    logic [7:0] score;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, fc_ready, result_ack;
  logic [7:0] num [10];
  int         checks = 0;
  int         errors = 0;
  res_t       sq[$];
  res_t       uq[$];

  always #5 clk = ~clk;

  fc_infer_if if_s ();
  fc_infer_if if_u ();

  assign if_s.start = start;      assign if_u.start = start;
  assign if_s.fc_ready = fc_ready; assign if_u.fc_ready = fc_ready;
  assign if_s.result_ack = result_ack; assign if_u.result_ack = result_ack;
  assign if_s.num_0 = num[0]; assign if_u.num_0 = num[0];
  assign if_s.num_1 = num[1]; assign if_u.num_1 = num[1];
  assign if_s.num_2 = num[2]; assign if_u.num_2 = num[2];
  assign if_s.num_3 = num[3]; assign if_u.num_3 = num[3];
  assign if_s.num_4 = num[4]; assign if_u.num_4 = num[4];
  assign if_s.num_5 = num[5]; assign if_u.num_5 = num[5];
  assign if_s.num_6 = num[6]; assign if_u.num_6 = num[6];
  assign if_s.num_7 = num[7]; assign if_u.num_7 = num[7];
  assign if_s.num_8 = num[8]; assign if_u.num_8 = num[8];
  assign if_s.num_9 = num[9]; assign if_u.num_9 = num[9];

  fc_infer_initiator #(.SIGNED_SCORES(1'b1), .TIMEOUT_CYCLES(TMO)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .bus(if_s));
  fc_infer_initiator #(.SIGNED_SCORES(1'b0), .TIMEOUT_CYCLES(TMO)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .bus(if_u));

  function automatic res_t argmax(input logic [7:0] sc [10], input bit sgn);
    res_t r;
    int   bi, bv, v;
    bi = 0;
    bv = sgn ? int'($signed(sc[0])) : int'(sc[0]);
    for (int i = 1; i < 10; i++) begin
      v = sgn ? int'($signed(sc[i])) : int'(sc[i]);
      if (v > bv) begin
        bv = v;
        bi = i;
      end
    end
    r.idx   = 4'(bi);
    r.score = sc[bi];
    return r;
  endfunction

  // One request through the FC model; hold = cycles fc_ready stays high after fc_valid drops.
  task automatic run_inf(input logic [7:0] sc [10], input int delay, input int hold,
                         input bit busy_starts);
    int lat, low_at, drop_lat, reassert, exp_lat;
    bit done;
    @(negedge clk); start = 1'b1;
    sq.push_back(argmax(sc, 1'b1));
    uq.push_back(argmax(sc, 1'b0));
    @(negedge clk); start = 1'b0;
    checks++;
    if (if_s.fc_valid !== 1'b1 || if_s.busy !== 1'b1 || if_s.timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL req_entry fc_valid=%b busy=%b timeout_err=%b required 1 1 0",
               if_s.fc_valid, if_s.busy, if_s.timeout_err);
    end
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      start = busy_starts && (i % 3 == 0);
    end
    start = 1'b0;
    num = sc;
    fc_ready = 1'b1;
    lat = 0; low_at = 0; drop_lat = 0; reassert = 0; done = 1'b0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        checks++;
        if (if_s.fc_valid !== 1'b0) begin
          errors++;
          $display("FAIL fc_valid_drop fc_valid=%b one cycle after fc_ready required 0", if_s.fc_valid);
        end
      end
      if (low_at > 0 && if_s.fc_valid !== 1'b0) reassert++;
      if (if_s.result_valid === 1'b1) done = 1'b1;
      else begin
        if (low_at == 0 && if_s.fc_valid === 1'b0) low_at = lat;
        if (busy_starts) start = (lat % 2 == 0);
        if (fc_ready && low_at > 0 && lat - low_at >= hold) begin
          fc_ready = 1'b0;
          drop_lat = lat;
          for (int i = 0; i < 10; i++) num[i] = 8'($urandom);
        end
      end
    end
    start = 1'b0;
    exp_lat = (drop_lat + 1 > 11) ? drop_lat + 1 : 11;
    checks++;
    if (!done || lat != exp_lat) begin
      errors++;
      $display("FAIL result_latency got %0d cycles (done=%b) required %0d", lat, done, exp_lat);
    end
    checks++;
    if (reassert != 0 || if_u.result_valid !== 1'b1) begin
      errors++;
      $display("FAIL fc_valid_reassert count=%0d unsigned_rv=%b required 0 1", reassert, if_u.result_valid);
    end
  endtask

  // Compare presented result against the scoreboard, hold ack, then retire it.
  task automatic finish_result(input int hold_ack, input bit start_with_ack);
    res_t es, eu;
    int   bad;
    if (sq.size() == 0 || uq.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty sizes %0d %0d required nonzero", sq.size(), uq.size());
      return;
    end
    es = sq.pop_front();
    eu = uq.pop_front();
    checks++;
    if (if_s.class_idx !== es.idx || if_s.class_score !== es.score) begin
      errors++;
      $display("FAIL signed_result idx=%0d score=%0d required idx=%0d score=%0d",
               if_s.class_idx, if_s.class_score, es.idx, es.score);
    end
    checks++;
    if (if_u.class_idx !== eu.idx || if_u.class_score !== eu.score) begin
      errors++;
      $display("FAIL unsigned_result idx=%0d score=%0d required idx=%0d score=%0d",
               if_u.class_idx, if_u.class_score, eu.idx, eu.score);
    end
    bad = 0;
    for (int i = 0; i < hold_ack; i++) begin
      @(negedge clk);
      if (if_s.result_valid !== 1'b1 || if_s.class_idx !== es.idx || if_s.class_score !== es.score)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL result_hold unstable cycles=%0d required 0", bad);
    end
    result_ack = 1'b1;
    start = start_with_ack;
    @(negedge clk);
    result_ack = 1'b0;
    start = 1'b0;
    checks++;
    if (if_s.result_valid !== 1'b0 || if_s.busy !== 1'b0 || if_s.fc_valid !== 1'b0) begin
      errors++;
      $display("FAIL ack_retire rv=%b busy=%b fc_valid=%b required 0 0 0",
               if_s.result_valid, if_s.busy, if_s.fc_valid);
    end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (if_s.fc_valid !== 1'b0 || if_s.busy !== 1'b0 || if_s.class_idx !== es.idx) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_after_ack bad_cycles=%0d required 0", bad);
    end
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if ({if_s.busy, if_s.fc_valid, if_s.result_valid, if_s.class_idx, if_s.class_score,
         if_s.timeout_err, if_u.busy, if_u.fc_valid, if_u.result_valid} !== '0) begin
      errors++;
      $display("FAIL %s busy=%b fc_valid=%b rv=%b idx=%0d score=%0d terr=%b required all 0",
               name, if_s.busy, if_s.fc_valid, if_s.result_valid, if_s.class_idx,
               if_s.class_score, if_s.timeout_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset_values");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("idle_after_reset");
  endtask

  task automatic test_basic();
    logic [7:0] sc [10];
    sc = '{8'd5, 8'd9, 8'd3, 8'd120, 8'd7, 8'd0, 8'd1, 8'd2, 8'd4, 8'd6};
    run_inf(sc, 20, 1, 1'b0);
    finish_result(0, 1'b0);
  endtask

  task automatic test_signed();
    logic [7:0] sc [10];
    for (int i = 0; i < 10; i++) sc[i] = 8'hF0;
    sc[7] = 8'h01;
    run_inf(sc, 2, 1, 1'b0);
    finish_result(0, 1'b0);
  endtask

  task automatic test_tie();
    logic [7:0] sc [10];
    for (int i = 0; i < 10; i++) sc[i] = 8'd10;
    sc[2] = 8'd50;
    sc[8] = 8'd50;
    run_inf(sc, 0, 2, 1'b0);
    finish_result(0, 1'b0);
  endtask

  task automatic test_handshake_hold();
    logic [7:0] sc [10];
    sc = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'h90, 8'd9};
    run_inf(sc, 5, 15, 1'b1);
    finish_result(0, 1'b0);
  endtask

  task automatic test_ack_reset();
    logic [7:0] sc [10];
    int bad;
    sc = '{8'h80, 8'd3, 8'hFF, 8'd77, 8'd12, 8'd77, 8'h7F, 8'd0, 8'd1, 8'd2};
    run_inf(sc, 1, 0, 1'b0);
    finish_result(30, 1'b1);
    // Reset in the middle of a scan: nothing from this request may surface.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    num = sc;
    fc_ready = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("reset_in_scan");
    @(negedge clk);
    rst_n = 1'b1;
    fc_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (if_s.result_valid !== 1'b0 || if_s.fc_valid !== 1'b0 || if_s.busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL post_reset_quiet bad_cycles=%0d required 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] sc [10];
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 10; i++) sc[i] = 8'($urandom);
      run_inf(sc, n, n % 2, 1'b0);
      finish_result(n, 1'b0);
    end
  endtask

`ifdef FC_INFER_TIMEOUT_EN
  task automatic test_timeout();
    logic [7:0] sc [10];
    int hi;
    @(negedge clk); start = 1'b1;
    sq.push_back('{idx: 4'hF, score: 8'd0});
    uq.push_back('{idx: 4'hF, score: 8'd0});
    @(negedge clk); start = 1'b0;
    hi = 0;
    while (if_s.fc_valid === 1'b1 && hi < 50) begin
      hi++;
      @(negedge clk);
    end
    checks++;
    if (hi != 8 || if_s.timeout_err !== 1'b1 || if_s.class_idx !== 4'hF || if_s.class_score !== 8'd0) begin
      errors++;
      $display("FAIL timeout_abort req_cycles=%0d terr=%b idx=%h score=%0d required 8 1 f 0",
               hi, if_s.timeout_err, if_s.class_idx, if_s.class_score);
    end
    @(negedge clk);
    checks++;
    if (if_s.result_valid !== 1'b1) begin
      errors++;
      $display("FAIL timeout_result rv=%b required 1", if_s.result_valid);
    end
    finish_result(0, 1'b0);
    checks++;
    if (if_s.timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky terr=%b required 1", if_s.timeout_err);
    end
    for (int i = 0; i < 10; i++) sc[i] = 8'(i * 3);
    run_inf(sc, 2, 1, 1'b0);
    finish_result(0, 1'b0);
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    fc_ready = 1'b0;
    result_ack = 1'b0;
    for (int i = 0; i < 10; i++) num[i] = 8'd0;
    test_reset();
    test_basic();
    test_signed();
    test_tie();
    test_handshake_hold();
    test_ack_reset();
    test_back_to_back();
`ifdef FC_INFER_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1);
  end
endmodule

// File: doc/fc_infer_initiator.md
Name: fc_infer_initiator

Overview:
- Initiator/consumer side of the fully-connected layer's valid/ready handshake.
- On a start pulse it raises fc_valid, waits for fc_ready, then snapshots the ten 8-bit class scores.
- It scans the scores sequentially (argmax) and releases fc_valid.
- It presents the winning class index and score to the SoC register/bus side through a result_valid/result_ack handshake.

Parameters:
- SIGNED_SCORES, 1, 1 = scores compared as two's-complement signed; 0 = unsigned.
- TIMEOUT_CYCLES, 16'd4096, maximum REQ cycles before abort (used only with FC_INFER_TIMEOUT_EN).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  single-cycle request to run one inference; honoured only in IDLE
- busy  output  1  high in every state except IDLE
- fc_valid  output  1  request to FC layer; registered
- fc_ready  input  1  FC layer results stable while high
- num_0..num_9  input  8 each  class scores from FC layer
- result_valid  output  1  class_idx/class_score valid; held until acknowledged
- result_ack  input  1  consumer acceptance of the result
- class_idx  output  4  argmax index, 0..9; 4'hF = aborted
- class_score  output  8  score of winning class
- timeout_err  output  1  sticky abort flag (FC_INFER_TIMEOUT_EN only)

Behaviour:
- Reset values: fc_valid=0, busy=0, result_valid=0, class_idx=0, class_score=0, timeout_err=0, state=IDLE, scan counter=0.
- States: IDLE, REQ, SCAN, DRAIN, DONE.
- IDLE:
  - start=1 -> REQ; fc_valid=1 from the next cycle.
  - start outside IDLE is ignored; there is no queueing.
- REQ:
  - fc_valid held high, counter idle.
  - fc_ready sampled 1 -> latch num_0..num_9 into a 10x8 snapshot register file; best_score=num_0, best_idx=0, cnt=1; fc_valid=0 next cycle; -> SCAN.
- SCAN:
  - Each cycle compares snap[cnt] against best_score (strict greater-than, signedness per SIGNED_SCORES).
  - On greater: best_score/best_idx update. Ties keep the lower index.
  - cnt increments 1..9; at cnt==9 -> DRAIN.
  - Exactly 9 SCAN cycles.
- DRAIN:
  - Waits for fc_ready==0, so the FC layer has returned to idle before a new request is possible.
  - fc_ready==0 -> DONE, with class_idx/class_score loaded from best_idx/best_score.
  - fc_ready high indefinitely -> stays in DRAIN.
- DONE:
  - result_valid=1; class_idx/class_score stable.
  - result_ack=1 -> result_valid=0 next cycle; -> IDLE.
  - result_ack outside DONE is ignored.
  - start and result_ack in the same DONE cycle: ack taken, start ignored.
- Latency: start at edge k, fc_ready first high at edge r -> result_valid rises at edge r+11 when fc_ready falls within the scan window (9 SCAN + 1 DRAIN + output register).
- fc_valid never reasserts while fc_ready is high; a minimum of 1 cycle of fc_valid low separates requests.
- class_idx/class_score hold their last value after the ack until the next DONE.
- Async reset mid-operation returns to IDLE immediately and drops fc_valid. The FC layer sees valid low and returns to idle on its own.

Optional Feature:
- Macro: FC_INFER_TIMEOUT_EN.
- With the macro:
  - A 16-bit counter clears on REQ entry and increments each REQ cycle.
  - Reaching TIMEOUT_CYCLES without fc_ready -> fc_valid=0, timeout_err=1, class_idx=4'hF, class_score=0, -> DRAIN, then normal DONE/ack.
  - timeout_err clears on the next accepted start.
- Without the macro: no counter; REQ waits indefinitely; timeout_err is tied 0.

Test Plan:
- Basic: start, fc_ready after 20 cycles, scores {5,9,3,120,7,0,1,2,4,6} -> class_idx=3, class_score=8'd120, result_valid exactly 11 cycles after fc_ready rise, fc_valid low 1 cycle after fc_ready.
- Signed: SIGNED_SCORES=1, scores all 8'hF0 except num_7=8'h01 -> idx 7. With SIGNED_SCORES=0, same vector -> idx 0 (tie on 0xF0, lowest index).
- Tie: num_2=num_8=8'd50, others 8'd10 -> class_idx=2.
- Handshake hold: FC model keeps fc_ready high 15 cycles after valid drops -> stays DRAIN, result_valid only after fc_ready falls; start pulses while busy produce no second fc_valid.
- Ack/reset: result_ack withheld 30 cycles -> outputs stable. Ack -> IDLE. rst_n pulsed during SCAN -> all outputs at reset values, no result_valid.
- Timeout (FC_INFER_TIMEOUT_EN, TIMEOUT_CYCLES=8): no fc_ready -> fc_valid low after 8 REQ cycles, timeout_err=1, class_idx=4'hF. Next start clears timeout_err.
